farm_regfile: RTL and testbench
===============================

FARM_REGFILE -- requirements
Module: farm_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two, 4..64.
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port we  in  1: write enable.
REQ-007 SHALL have port waddr  in  log2(NREG): write index.
REQ-008 SHALL have port wdata  in  XLEN: write data.
REQ-009 SHALL have port raddr  in  NRD x log2(NREG): packed read indices.
REQ-010 SHALL have port rdata  out  NRD x XLEN: packed read data.
REQ-011 SHALL have port dump_req  in  1: start-dump pulse, sampled in IDLE only.
REQ-012 SHALL have port dump_lo  in  log2(NREG): first index to dump.
REQ-013 SHALL have port dump_hi  in  log2(NREG): last index to dump.
REQ-014 SHALL have port dump_abort  in  1: terminate the dump in progress.
REQ-015 SHALL have port dump_valid  out  1: dump beat present.
REQ-016 SHALL have port dump_ready  in  1: dump beat accepted when high with dump_valid.
REQ-017 SHALL have port dump_idx  out  log2(NREG): index of the current beat.
REQ-018 SHALL have port dump_data  out  XLEN: register value of the current beat.
REQ-019 SHALL have port dump_busy  out  1: high in any state other than IDLE.
REQ-020 SHALL have port dump_done  out  1: one-cycle pulse on dump completion or abort.

Function
REQ-021 Register 0 SHALL read as zero at all times; writes to it SHALL be discarded.
REQ-022 Write: when we=1, SHALL update mem[waddr]<=wdata on the clock edge.
REQ-023 Read: rdata[i] SHALL be combinational from mem[raddr[i]] with zero latency.
REQ-024 Dump FSM SHALL have states IDLE, LOAD, BEAT and FIN.
REQ-025 IDLE->LOAD SHALL occur on dump_req=1, latching lo and hi; if dump_lo>dump_hi, IDLE->FIN with no beats.
REQ-026 LOAD SHALL capture mem[ptr] (pre-write value on a same-cycle write) into dump_data, then go to BEAT.
REQ-027 In BEAT, dump_valid=1, with dump_idx and dump_data stable until accepted.
REQ-028 On acceptance, the FSM SHALL go to FIN if ptr==hi, else increment ptr and go to LOAD; throughput is 1 beat per 2 cycles.
REQ-029 FIN SHALL assert dump_done for 1 cycle, then go to IDLE.
REQ-030 dump_abort=1 in LOAD or BEAT SHALL go to FIN next cycle; an un-accepted beat SHALL be dropped.
REQ-031 dump_req while busy SHALL be ignored; dump_abort in IDLE SHALL be ignored.
REQ-032 The pointer SHALL NOT wrap: hi=NREG-1 terminates without overflow.

Reset
REQ-033 rst SHALL clear all registers to 0, set the FSM to IDLE, and drive dump_valid, dump_busy and dump_done to 0 and dump_idx and dump_data to 0.
REQ-034 rst asserted mid-dump SHALL abandon the dump with no dump_done pulse.

Configuration
REQ-035 With macro FARM_RF_BYPASS_EN defined, a read whose raddr[i]==waddr!=0 while we=1 SHALL return wdata in the same cycle.
REQ-036 Without FARM_RF_BYPASS_EN, that read SHALL return the old value.
REQ-037 FARM_RF_BYPASS_EN SHALL NOT affect dump capture (REQ-026).

Structure
REQ-038 farm_pkg SHALL hold the dump-state enum (IDLE, LOAD, BEAT, FIN) and the default XLEN/NREG constants.
REQ-039 The dump FSM and pointer SHALL be sub-module farm_rf_dump_fsm; storage and read ports SHALL stay in farm_regfile.

Verification
REQ-040 Write x5=0xDEADBEEF, read it on port 1 the next cycle -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-041 Same-cycle write x7=0xA5A5A5A5 and read x7 -> 0xA5A5A5A5 with FARM_RF_BYPASS_EN, the prior value without.
REQ-042 Dump lo=1, hi=3 with dump_ready=1 -> beats idx 1,2,3 with the correct data, then one dump_done pulse, busy low after.
REQ-043 Dump lo=2, hi=2 with dump_ready low for 5 cycles -> dump_valid held, idx=2 and data stable, a single beat on release.
REQ-044 Dump lo=4, hi=2 -> zero beats, dump_done pulses 2 cycles after dump_req.
REQ-045 Abort in the second beat of a 0..31 dump -> no further beats, done pulse; rst mid-dump -> IDLE, all outputs 0.

Source files
------------

// File: rtl/farm_pkg.sv
// Shared types and default sizes for the farm register file and its dump engine.
package farm_pkg;

  localparam int FARM_XLEN = 32;
  localparam int FARM_NREG = 32;
  localparam int FARM_NRD  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BEAT = 2'd2,
    FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/farm_rf_dump_fsm.sv
// Dump engine: walks registers lo..hi, presenting one valid/ready beat per register.
module farm_rf_dump_fsm
  import farm_pkg::*;
#(
  parameter int XLEN = FARM_XLEN,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump_req,
  input  logic [AW-1:0]   dump_lo,
  input  logic [AW-1:0]   dump_hi,
  input  logic            dump_abort,
  input  logic            dump_ready,
  input  logic [XLEN-1:0] load_data,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_valid,
  output logic            dump_busy,
  output logic            dump_done
);

  dump_state_e   state;
  logic [AW-1:0] hi_q;

  // dump_idx doubles as the walk pointer; it stops at hi and never wraps.
  // dump_done is registered from FIN, so it appears the cycle after FIN.
  // NOTE: every state-holding assignment is non-blocking so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dump_idx   <= '0;
      hi_q       <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= (state == FIN);
      case (state)
        IDLE: begin
          if (dump_req) begin
            dump_idx  <= dump_lo;
            hi_q      <= dump_hi;
            dump_busy <= 1'b1;
            state     <= (dump_lo > dump_hi) ? FIN : LOAD;
          end
        end
        LOAD: begin
          if (dump_abort) begin
            state <= FIN;
          end else begin
            dump_data  <= load_data;
            dump_valid <= 1'b1;
            state      <= BEAT;
          end
        end
        BEAT: begin
          if (dump_abort || (dump_ready && dump_idx == hi_q)) begin
            dump_valid <= 1'b0;
            state      <= FIN;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_idx   <= dump_idx + 1'b1;
            state      <= LOAD;
          end
        end
        FIN: begin
          dump_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/farm_regfile.sv
// Multi-read-port register file with x0 hardwired to zero and a register dump engine.
// Define FARM_RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module farm_regfile
  import farm_pkg::*;
#(
  parameter int XLEN = FARM_XLEN,
  parameter int NREG = FARM_NREG,
  parameter int NRD  = FARM_NRD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(NREG)-1:0]       waddr,
  input  logic [XLEN-1:0]               wdata,
  input  logic [NRD*$clog2(NREG)-1:0]   raddr,
  output logic [NRD*XLEN-1:0]           rdata,
  input  logic                          dump_req,
  input  logic [$clog2(NREG)-1:0]       dump_lo,
  input  logic [$clog2(NREG)-1:0]       dump_hi,
  input  logic                          dump_abort,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [$clog2(NREG)-1:0]       dump_idx,
  output logic [XLEN-1:0]               dump_data,
  output logic                          dump_busy,
  output logic                          dump_done
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] load_data;

  // NOTE: the array is reset because software may dump registers it never wrote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];
`ifdef FARM_RF_BYPASS_EN
    assign rdata[i*XLEN +: XLEN] = (we && waddr != '0 && ra == waddr) ? wdata : mem[ra];
`else
    assign rdata[i*XLEN +: XLEN] = mem[ra];
`endif
  end

  // Dump capture always sees the stored (pre-write) value, never the bypass.
  assign load_data = mem[dump_idx];

  farm_rf_dump_fsm #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_req   (dump_req),
    .dump_lo    (dump_lo),
    .dump_hi    (dump_hi),
    .dump_abort (dump_abort),
    .dump_ready (dump_ready),
    .load_data  (load_data),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_valid (dump_valid),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

endmodule

// File: tb/tb_farm_regfile.sv
// Self-checking bench for farm_regfile: transaction-level model plus directed literal checks.
module tb_farm_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
`ifdef FARM_RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [XLEN-1:0]      wdata;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic                 dump_req;
  logic [AW-1:0]        dump_lo;
  logic [AW-1:0]        dump_hi;
  logic                 dump_abort;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [AW-1:0]        dump_idx;
  logic [XLEN-1:0]      dump_data;
  logic                 dump_busy;
  logic                 dump_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  farm_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .dump_req   (dump_req),
    .dump_lo    (dump_lo),
    .dump_hi    (dump_hi),
    .dump_abort (dump_abort),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: register contents plus a dump described as a list of pending indices
  // and event times (an event seen in cycle c shows its effect on the outputs in cycle c+2).
  logic [XLEN-1:0] model [NREG];
  int              cyc = 0;
  bit              m_active = 1'b0;
  bit              m_in_beat = 1'b0;
  int              m_start, m_next_valid, m_done = -1;
  int              m_q[$];
  logic [XLEN-1:0] m_data;
  int              ra;
  logic [XLEN-1:0] rexp;
  bit              exp_busy, exp_done;

  int              log_idx[$];
  logic [XLEN-1:0] log_data[$];
  int              done_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (model[i]) model[i] = '0;
    end else if (we && waddr != '0) begin
      model[waddr] = wdata;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0; m_in_beat = 1'b0; m_done = -1; m_next_valid = -1; m_q.delete();
      check("rst_valid", dump_valid, 0);
      check("rst_busy", dump_busy, 0);
      check("rst_done", dump_done, 0);
      check("rst_idx", dump_idx, 0);
      check("rst_data", dump_data, 0);
      check("rst_rdata", rdata, 0);
    end else begin
      for (int i = 0; i < NRD; i++) begin
        ra   = int'(raddr[i*AW +: AW]);
        rexp = model[ra];
        if (BYPASS && we && waddr != '0 && int'(waddr) == ra) rexp = wdata;
        check("rdata", rdata[i*XLEN +: XLEN], rexp);
      end
      if (m_active && m_done < 0 && cyc == m_next_valid) m_in_beat = 1'b1;
      exp_busy = m_active && cyc > m_start && (m_done < 0 || cyc < m_done);
      exp_done = (cyc == m_done);
      if (exp_done) m_active = 1'b0;
      check("dump_valid", dump_valid, m_in_beat);
      check("dump_busy", dump_busy, exp_busy);
      check("dump_done", dump_done, exp_done);
      if (m_in_beat) begin
        check("dump_idx", dump_idx, m_q[0]);
        check("dump_data", dump_data, m_data);
      end
      if (dump_valid && dump_ready) begin
        log_idx.push_back(int'(dump_idx));
        log_data.push_back(dump_data);
      end
      if (dump_done) done_cnt++;
      if (m_active && m_done < 0) begin
        if (dump_abort) begin
          m_done = cyc + 2; m_in_beat = 1'b0; m_next_valid = -1;
        end else if (m_in_beat && dump_ready) begin
          void'(m_q.pop_front());
          m_in_beat = 1'b0;
          if (m_q.size() == 0) m_done = cyc + 2;
          else m_next_valid = cyc + 2;
        end
      end else if (!m_active && dump_req) begin
        m_active = 1'b1; m_start = cyc; m_done = -1; m_next_valid = -1; m_q.delete();
        if (dump_lo > dump_hi) m_done = cyc + 2;
        else begin
          for (int k = int'(dump_lo); k <= int'(dump_hi); k++) m_q.push_back(k);
          m_next_valid = cyc + 2;
        end
      end
      // Registers still hold pre-edge values here, which is what the load step captures.
      if (m_active && m_done < 0 && m_next_valid == cyc + 1) m_data = model[m_q[0]];
    end
  end

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    we = 1'b1; waddr = AW'(a); wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic clear_log();
    log_idx.delete(); log_data.delete(); done_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget && done_cnt == 0; t++) tick();
    tick(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    dump_req = 1'b0; dump_lo = '0; dump_hi = '0; dump_abort = 1'b0; dump_ready = 1'b0;
    tick(2);
    @(negedge clk);
    check("reset_rdata", rdata, 0);
    check("reset_busy", dump_busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // x5 write then read on port 1; x0 writes are dropped
    wr(5, 32'hDEAD_BEEF);
    raddr = {AW'(5), AW'(0)};
    @(negedge clk);
    check("x5_port1", rdata[2*XLEN-1:XLEN], 32'hDEAD_BEEF);
    wr(0, 32'h0000_1234);
    raddr = '0;
    @(negedge clk);
    check("x0_port0", rdata[XLEN-1:0], 0);
    check("x0_port1", rdata[2*XLEN-1:XLEN], 0);

    // same-cycle write/read of x7
    wr(7, 32'h1111_1111);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr = {AW'(0), AW'(7)};
    @(negedge clk);
    check("x7_same_cycle", rdata[XLEN-1:0], BYPASS ? 32'hA5A5_A5A5 : 32'h1111_1111);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("x7_after", rdata[XLEN-1:0], 32'hA5A5_A5A5);

    // dump 1..3 with ready held high
    wr(1, 32'h0000_0101); wr(2, 32'h0000_0202); wr(3, 32'h0000_0303);
    clear_log();
    dump_ready = 1'b1; dump_lo = 5'd1; dump_hi = 5'd3; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(40);
    check("d13_beats", log_idx.size(), 3);
    if (log_idx.size() == 3) begin
      check("d13_idx0", log_idx[0], 1);
      check("d13_idx1", log_idx[1], 2);
      check("d13_idx2", log_idx[2], 3);
      check("d13_data0", log_data[0], 32'h0101);
      check("d13_data1", log_data[1], 32'h0202);
      check("d13_data2", log_data[2], 32'h0303);
    end
    check("d13_done", done_cnt, 1);
    check("d13_busy_after", dump_busy, 0);

    // dump 2..2 with a 5-cycle stall
    clear_log();
    dump_ready = 1'b0; dump_lo = 5'd2; dump_hi = 5'd2; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_valid", dump_valid, 1);
      check("stall_idx", dump_idx, 2);
      check("stall_data", dump_data, 32'h0202);
      tick();
    end
    dump_ready = 1'b1;
    wait_done(20);
    check("stall_beats", log_idx.size(), 1);
    check("stall_done", done_cnt, 1);

    // empty range lo=4 hi=2
    clear_log();
    dump_lo = 5'd4; dump_hi = 5'd2; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    @(negedge clk);
    check("empty_done_c1", dump_done, 0);
    check("empty_busy_c1", dump_busy, 1);
    tick();
    @(negedge clk);
    check("empty_done_c2", dump_done, 1);
    tick(2);
    check("empty_beats", log_idx.size(), 0);
    check("empty_done_cnt", done_cnt, 1);

    // abort during the second beat of a 0..31 dump
    clear_log();
    dump_ready = 1'b1; dump_lo = 5'd0; dump_hi = 5'd31; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int t = 0; t < 10 && log_idx.size() == 0; t++) tick();
    dump_ready = 1'b0;
    for (int t = 0; t < 10 && !dump_valid; t++) tick();
    check("abort_second_valid", dump_valid, 1);
    check("abort_second_idx", dump_idx, 1);
    dump_abort = 1'b1;
    tick();
    dump_abort = 1'b0;
    dump_ready = 1'b1;
    wait_done(10);
    tick(3);
    check("abort_beats", log_idx.size(), 1);
    check("abort_done", done_cnt, 1);
    check("abort_busy", dump_busy, 0);

    // reset in the middle of a dump
    clear_log();
    dump_ready = 1'b0; dump_lo = 5'd0; dump_hi = 5'd31; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid", dump_valid, 0);
    check("rstmid_busy", dump_busy, 0);
    check("rstmid_idx", dump_idx, 0);
    check("rstmid_data", dump_data, 0);
    tick();
    rst = 1'b0;
    tick(4);
    check("rstmid_no_done", done_cnt, 0);

    // randomized traffic checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom);
      wdata = $urandom;
      raddr = (NRD*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[AW-1:0] = waddr;
      dump_req   = ($urandom_range(0, 5) == 0);
      dump_lo    = AW'($urandom_range(0, NREG-1));
      if ($urandom_range(0, 7) == 0) dump_hi = AW'($urandom_range(0, NREG-1));
      else dump_hi = AW'((int'(dump_lo) + $urandom_range(0, 4) > NREG-1) ?
                         NREG-1 : int'(dump_lo) + $urandom_range(0, 4));
      dump_abort = ($urandom_range(0, 59) == 0);
      dump_ready = ($urandom_range(0, 9) < 7);
      if (n == 1500) begin
        rst = 1'b1; we = 1'b0;
      end
      tick();
      rst = 1'b0;
    end
    we = 1'b0; dump_req = 1'b0; dump_abort = 1'b0; dump_ready = 1'b1;
    tick(80);
    check("final_idle", dump_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
